// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and status register.
// TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t          r_state, w_state_n;
  logic [15:0]     r_baud, w_baud_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_data;
  logic            r_txd, w_txd_n;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            w_hit_tx, w_hit_st, w_full, w_empty, w_push, w_pop, w_tick;
  logic            w_unused;
  assign w_hit_tx = a[31:2] == BASE_ADDR[31:2];
  assign w_hit_st = a[31:2] == BASE_ADDR[31:2] + 30'd1;
  assign sel      = w_hit_tx | w_hit_st;
  assign w_full   = r_cnt == CW'(FIFO_DEPTH);
  assign w_empty  = r_cnt == '0;
  assign w_push   = we & w_hit_tx & ~w_full;
  assign w_tick   = r_baud == BAUD_MAX;
  assign txd      = r_txd;
  assign rd       = w_hit_st ? {23'd0, PAR_EN, 4'(r_cnt), r_ovf, w_empty, w_full, r_state != S_IDLE} : 32'd0;
  assign w_unused = &{1'b0, a[1:0], wd[31:8]};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_n;
  // next state, baud/bit counters and FIFO pop; a pop happens only on frame start
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = w_tick ? 16'd0 : r_baud + 16'd1;
    w_bit_n   = r_bit;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n = 16'd0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
        end
      end
      S_START: if (w_tick) begin
        w_state_n = S_DATA;
        w_bit_n   = 3'd0;
      end
      S_DATA: if (w_tick) begin
        w_bit_n = r_bit + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (r_bit == 3'd7) w_state_n = S_PARITY;
`else
        if (r_bit == 3'd7) w_state_n = S_STOP;
`endif
      end
      S_PARITY: if (w_tick) w_state_n = S_STOP;
      S_STOP: if (w_tick) begin
        w_pop     = !w_empty;
        w_state_n = w_empty ? S_IDLE : S_START;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  // line level for the state being entered, so txd comes straight from a flop
  always_comb begin
    w_txd_n = (w_state_n == S_DATA) ? r_data[w_bit_n] : (w_state_n == S_PARITY) ? ^r_data : (w_state_n != S_START);
  end
  // serialiser datapath
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_baud <= '0;
      r_bit  <= '0;
      r_data <= '0;
      r_txd  <= 1'b1;
    end else begin
      r_baud <= w_baud_n;
      r_bit  <= w_bit_n;
      r_txd  <= w_txd_n;
      if (w_pop) r_data <= r_mem[r_rp];
    end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // FIFO storage
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wd[7:0];
  // sticky overflow: set by a TXDATA write while full, cleared by any STATUS write
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ovf <= 1'b0;
    else if (we & w_hit_st) r_ovf <= 1'b0;
    else if (we & w_hit_tx & w_full) r_ovf <= 1'b1;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench with a queue-based line model checked every cycle.
module tb_mmio_uart_tx;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = (PAR ? 11 : 10) * CPB;
  localparam logic [31:0] PB = PAR ? 32'h100 : 32'h0;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0;
  logic [31:0] a = 32'h0, wd = 32'h0;
  logic [31:0] rd;
  logic sel, txd;
  int ncmp = 0, nerr = 0, cyc = 0;
  int e0, e1;
  logic [7:0] mq[$];
  bit m_busy = 0, m_ovf = 0, m_full_pre;
  int m_pos = 0;
  logic [7:0] m_cur = 8'h0;
  mmio_uart_tx dut (.clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .sel(sel), .txd(txd));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  // model: a frame is a cycle count into a fixed bit sequence
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_busy = 0;
      m_pos = 0;
      m_ovf = 0;
    end else begin
      m_full_pre = mq.size() == DEPTH;
      if (m_busy) begin
        m_pos++;
        if (m_pos == FL) m_busy = 0;
      end
      if (!m_busy && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_busy = 1;
        m_pos = 0;
      end
      if (we && a[31:2] == 30'h400) begin
        if (m_full_pre) m_ovf = 1;
        else mq.push_back(wd[7:0]);
      end
      if (we && a[31:2] == 30'h401) m_ovf = 0;
    end
  end
  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    if (PAR && k == 9) return ^m_cur;
    return 1'b1;
  endfunction
  function automatic logic [31:0] exp_rd();
    logic [3:0] n;
    n = 4'(mq.size());
    if (a[31:2] != 30'h401) return 32'h0;
    return {23'd0, PAR, n, m_ovf, n == 0, n == 4'(DEPTH), m_busy};
  endfunction
  always @(negedge clk) begin
    chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
    chk("sel", {31'd0, sel}, {31'd0, a[31:2] == 30'h400 || a[31:2] == 30'h401});
    chk("rd", rd, exp_rd());
  end
  task automatic store(input logic [31:0] ad, input logic [31:0] d);
    we = 1'b1;
    a = ad;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    a = 32'h1004;
    wd = 32'h0;
    #1;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic probe(input string nm, input logic [31:0] ad, input logic [31:0] erd, input logic esel);
    a = ad;
    #1;
    chk({nm, "_rd"}, rd, erd);
    chk({nm, "_sel"}, {31'd0, sel}, {31'd0, esel});
    @(posedge clk);
    #1;
  endtask
  task automatic frame_bits(input string nm, input int t1, input logic [10:0] f, input int nb);
    for (int k = 0; k < nb; k++) begin
      wait_to(t1 + 16 * k + 8);
      chk(nm, {31'd0, txd}, {31'd0, f[k]});
      if (k == 5) chk({nm, "_busy"}, {31'd0, rd[0]}, 32'd1);
    end
  endtask
  initial begin
    logic [10:0] f;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_txd", {31'd0, txd}, 32'd1);
    probe("st_read", 32'h1004, 32'h4 | PB, 1'b1);
    probe("st_lowbits", 32'h1007, 32'h4 | PB, 1'b1);
    probe("tx_read", 32'h1000, 32'h0, 1'b1);
    probe("miss", 32'h0100, 32'h0, 1'b0);
    a = 32'h1004;
    store(32'h1000, 32'hFFFF_FF55);
    e0 = cyc;
    e1 = e0 + 1;
    chk("lat_pre", {31'd0, txd}, 32'd1);
    wait_to(e1);
    chk("lat_fall", {31'd0, txd}, 32'd0);
    f = PAR ? 11'b10_0101_0101_0 : 11'b11_0101_0101_0;
    frame_bits("bit55", e1, f, 10);
    wait_to(e1 + FL - 1);
    chk("end_m1", rd, 32'h5 | PB);
    wait_to(e1 + FL);
    chk("end_st", rd, 32'h4 | PB);
    chk("end_txd", {31'd0, txd}, 32'd1);
    store(32'h1000, 32'h11);
    e1 = cyc + 1;
    store(32'h1000, 32'h22);
    store(32'h1000, 32'h33);
    store(32'h1000, 32'h44);
    store(32'h1000, 32'h55);
    chk("st_full", rd, 32'h43 | PB);
    store(32'h1000, 32'h66);
    chk("st_ovf", rd, 32'h4B | PB);
    store(32'h1004, 32'hDEAD_BEEF);
    chk("st_ovf_clr", rd, 32'h43 | PB);
    wait_to(e1 + FL - 1);
    chk("b2b_stop", {31'd0, txd}, 32'd1);
    wait_to(e1 + FL);
    chk("b2b_start", {31'd0, txd}, 32'd0);
    chk("b2b_st", rd, 32'h31 | PB);
    wait_to(e1 + 5 * FL - 1);
    chk("drain_m1", rd, 32'h5 | PB);
    wait_to(e1 + 5 * FL);
    chk("drain_st", rd, 32'h4 | PB);
    store(32'h1000, 32'hA5);
    e1 = cyc + 1;
    wait_to(e1 + 40);
    chk("pre_rst", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_st", rd, 32'h4 | PB);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    store(32'h1000, 32'h3C);
    e1 = cyc + 1;
    f = PAR ? 11'b10_0011_1100_0 : 11'b11_0011_1100_0;
    frame_bits("bit3c", e1, f, PAR ? 11 : 10);
    wait_to(e1 + FL);
    chk("post_rst_st", rd, 32'h4 | PB);
`ifdef UART_TX_PARITY_EN
    store(32'h1000, 32'h07);
    e1 = cyc + 1;
    f = 11'b11_0000_0111_0;
    frame_bits("bit07", e1, f, 11);
    wait_to(e1 + 175);
    chk("par_m1", rd, 32'h105);
    wait_to(e1 + 176);
    chk("par_end", rd, 32'h104);
    store(32'h1000, 32'h03);
    e1 = cyc + 1;
    f = 11'b10_0000_0011_0;
    frame_bits("bit03", e1, f, 11);
    wait_to(e1 + 176);
`endif
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
